fetch_unit: RTL



---
 rtl/fetch_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem read at a
// time, and buffers returned words with their address in a 2-entry queue.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INST_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic [1:0]        dbg_state,
  output logic [1:0]        dbg_count
);

  // Handshakes: decode takes the head on any edge where inst_valid & inst_ready.
  // Memory side holds imem_req/imem_addr steady until a single-cycle imem_ack;
  // a request, once raised, is only abandoned by reset.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic [1:0]        count_q, count_d;
  logic              head_q, head_d;
  logic [ADDR_W-1:0] fifo_pc_q [2];
  logic [ADDR_W-1:0] fifo_pc_d [2];
  logic [INST_W-1:0] fifo_word_q [2];
  logic [INST_W-1:0] fifo_word_d [2];

  logic       pop;
  logic [1:0] count_popped;
  logic       head_popped;
  logic       tail_idx;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    addr_d      = addr_q;
    count_d     = count_q;
    head_d      = head_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_word_d = fifo_word_q;

    pop          = (count_q != 2'd0) && inst_ready;
    count_popped = count_q - {1'b0, pop};
    head_popped  = head_q ^ pop;
    // Tail slot is computed from pre-pop state; a push only happens with count <= 1.
    tail_idx     = head_q ^ count_q[0];

    unique case (state_q)
      ST_IDLE: begin
        if (pc_load) begin
          fetch_pc_d = pc_target;
          count_d    = 2'd0;
          head_d     = 1'b0;
        end else begin
          count_d = count_popped;
          head_d  = head_popped;
          if (count_popped < 2'd2) begin
            state_d    = ST_REQ;
            addr_d     = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_ONE;
          end
        end
      end

      ST_REQ: begin
        if (pc_load) begin
          fetch_pc_d = pc_target;
          count_d    = 2'd0;
          head_d     = 1'b0;
          state_d    = imem_ack ? ST_IDLE : ST_DROP;
        end else begin
          count_d = count_popped;
          head_d  = head_popped;
          if (imem_ack) begin
            fifo_pc_d[tail_idx]   = addr_q;
            fifo_word_d[tail_idx] = imem_rdata;
            count_d               = count_popped + 2'd1;
            state_d               = ST_IDLE;
          end
        end
      end

      ST_DROP: begin
        if (pc_load) begin
          fetch_pc_d = pc_target;
          count_d    = 2'd0;
          head_d     = 1'b0;
        end else begin
          count_d = count_popped;
          head_d  = head_popped;
        end
        if (imem_ack) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      req_q      <= 1'b0;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_word_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      count_q     <= count_d;
      head_q      <= head_d;
      fifo_pc_q   <= fifo_pc_d;
      fifo_word_q <= fifo_word_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = (count_q != 2'd0);
  assign inst       = fifo_word_q[head_q];
  assign inst_pc    = fifo_pc_q[head_q];
  assign dbg_state  = state_q;
  assign dbg_count  = count_q;

endmodule
